// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared encodings for the execute-stage divider.
package ex_div_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;
endpackage

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Results leave on the register-file write-back triple; decode stalls on busy_o.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  reg_wen_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  is_rem_q, is_rem_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic              is_signed, is_rem, a_neg, b_neg, ovf, special, last;
    logic [DATA_W-1:0] abs_a, abs_b, spec_res, quo_n, rem_n, quo_fix, rem_fix;
    logic [DATA_W:0]   trial, diff;

    always_comb begin
        is_signed = op_i == OP_DIV || op_i == OP_REM;
        is_rem    = op_i == OP_REM || op_i == OP_REMU;
        a_neg     = is_signed & dividend_i[DATA_W-1];
        b_neg     = is_signed & divisor_i[DATA_W-1];
        abs_a     = a_neg ? -dividend_i : dividend_i;
        abs_b     = b_neg ? -divisor_i : divisor_i;
        ovf       = is_signed && dividend_i == MIN_NEG && divisor_i == '1;
        special   = divisor_i == '0 || ovf;
        spec_res  = divisor_i == '0 ? (is_rem ? dividend_i : '1) : (is_rem ? '0 : MIN_NEG);
        // Trial subtraction in DATA_W+1 bits: the top bit of diff is the borrow.
        trial     = {rem_q, quo_q[DATA_W-1]};
        diff      = trial - {1'b0, dvs_q};
        quo_n     = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
        rem_n     = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_fix   = (neg_a_q ^ neg_b_q) ? -quo_n : quo_n;
        rem_fix   = neg_a_q ? -rem_n : rem_n;
        last      = cnt_q == CNT_W'(DATA_W - 1);
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        is_rem_d  = is_rem_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        wdata_d   = wdata_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && start_i) begin
            state_d  = special ? DONE : CALC;
            quo_d    = abs_a;
            rem_d    = '0;
            dvs_d    = abs_b;
            cnt_d    = '0;
            waddr_d  = reg_waddr_i;
            is_rem_d = is_rem;
            neg_a_d  = a_neg;
            neg_b_d  = b_neg;
            wdata_d  = special ? spec_res : wdata_q;
        end else if (state_q == CALC) begin
            quo_d   = quo_n;
            rem_d   = rem_n;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = last ? DONE : CALC;
            wdata_d = last ? (is_rem_q ? rem_fix : quo_fix) : wdata_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            waddr_q  <= '0;
            is_rem_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            is_rem_q <= is_rem_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE && !flush_i;
    assign reg_wdata_o = wdata_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wen_o   = done_o && waddr_q != '0;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized and directed checks of ex_div against a behavioural model.
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] dividend_i = '0, divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        busy_o, done_o, reg_wen_o;
    logic [31:0] reg_wdata_o;
    logic [4:0]  reg_waddr_o;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
        .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o), .reg_wen_o(reg_wen_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 0) r = op[1] ? a : 32'hFFFF_FFFF;
        else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = op[1] ? 32'h0 : 32'h8000_0000;
        else if (op == 2'b00) r = $signed(a) / $signed(b);
        else if (op == 2'b01) r = a / b;
        else if (op == 2'b10) r = $signed(a) % $signed(b);
        else r = a % b;
        return r;
    endfunction

    function automatic bit ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Transaction-level model: one pending result, cycles left until it appears.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_wdata = '0;
    logic [4:0]  m_addr = '0;
    logic        m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_left = 0; m_wdata = '0; m_addr = '0;
        end else if (flush_i) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_left == 0) m_busy = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) m_wdata = m_res;
            end
        end else if (start_i) begin
            m_busy = 1'b1;
            m_res  = ref_div(op_i, dividend_i, divisor_i);
            m_addr = reg_waddr_i;
            m_left = ref_special(op_i, dividend_i, divisor_i) ? 0 : 32;
            if (m_left == 0) m_wdata = m_res;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            m_done = m_busy && m_left == 0 && !flush_i;
            check("busy", 32'(busy_o), 32'(m_busy));
            check("done", 32'(done_o), 32'(m_done));
            check("wen", 32'(reg_wen_o), 32'(m_done && m_addr != 0));
            check("wdata", reg_wdata_o, m_wdata);
            if (m_done) check("waddr", 32'(reg_waddr_o), 32'(m_addr));
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        int n = 0;
        @(posedge clk); #1;
        while (busy_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_o) begin
            total++; bad++;
            $display("FAIL idle_wait: busy_o still 1 after 100 cycles");
        end
        op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic [31:0] exp, input int lat,
                               input logic exp_wen, input logic [4:0] exp_addr);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
            else n++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no done_o within 40 cycles, expected result %h", name, exp);
        end else begin
            check(name, reg_wdata_o, exp);
            check({name, "_wen"}, 32'(reg_wen_o), 32'(exp_wen));
            check({name, "_addr"}, 32'(reg_waddr_o), 32'(exp_addr));
            if (lat >= 0) check({name, "_lat"}, n, lat);
        end
    endtask

    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_wa;
    int          sel;
    bit          saw_done;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_wen", 32'(reg_wen_o), 0);
        check("rst_wdata", reg_wdata_o, 0);
        check("rst_waddr", 32'(reg_waddr_o), 0);
        rst = 1'b0;

        issue(OP_DIVU, 100, 7, 5);               expect_done("divu_100_7", 14, 32, 1, 5);
        issue(OP_DIV, 32'hFFFF_FFF9, 2, 3);      expect_done("div_m7_2", 32'hFFFF_FFFD, 32, 1, 3);
        issue(OP_REM, 32'hFFFF_FFF9, 2, 3);      expect_done("rem_m7_2", 32'hFFFF_FFFF, 32, 1, 3);
        issue(OP_REMU, 32'hFFFF_FFF9, 2, 9);     expect_done("remu_big_2", 1, 32, 1, 9);
        issue(OP_DIVU, 1234, 0, 6);              expect_done("divu_by0", 32'hFFFF_FFFF, 0, 1, 6);
        issue(OP_REM, 1234, 0, 6);               expect_done("rem_by0", 1234, 0, 1, 6);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 8); expect_done("div_ovf", 32'h8000_0000, 0, 1, 8);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 8); expect_done("rem_ovf", 0, 0, 1, 8);
        issue(OP_DIV, 32'h8000_0000, 2, 1);      expect_done("div_minneg_2", 32'hC000_0000, 32, 1, 1);

        // Flush on the 10th CALC cycle.
        issue(OP_DIV, 1000, 3, 4);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 0);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || reg_wen_o) saw_done = 1;
        end
        check("flush_nodone", 32'(saw_done), 0);
        issue(OP_DIV, 1000, 3, 4);               expect_done("after_flush", 333, 32, 1, 4);

        // Flush together with start in IDLE: nothing captured.
        @(posedge clk); #1;
        op_i = OP_DIVU; dividend_i = 9; divisor_i = 3; reg_waddr_i = 2; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", 32'(busy_o), 0);

        // Second start during CALC is ignored.
        issue(OP_DIVU, 1000, 10, 7);
        repeat (5) @(posedge clk);
        #1 op_i = OP_REMU; dividend_i = 77; divisor_i = 5; reg_waddr_i = 12; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        expect_done("ignore_start", 100, -1, 1, 7);

        issue(OP_DIVU, 50, 5, 0);                expect_done("x0_dest", 10, 32, 0, 0);

        // Asynchronous reset mid-CALC.
        issue(OP_DIVU, 12345, 6, 3);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 0);
        check("arst_done", 32'(done_o), 0);
        check("arst_wen", 32'(reg_wen_o), 0);
        check("arst_wdata", reg_wdata_o, 0);
        check("arst_waddr", 32'(reg_waddr_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_idle", 32'(busy_o), 0);

        for (int k = 0; k < 150; k++) begin
            r_op = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 9);
            r_a  = $urandom;
            r_b  = sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'($urandom_range(1, 16)) : $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) r_a = 32'h8000_0000;
            if (sel == 3) r_b = r_b >> $urandom_range(0, 31);
            r_wa = 5'($urandom_range(0, 31));
            issue(r_op, r_a, r_b, r_wa);
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                repeat ($urandom_range(0, 35)) @(posedge clk);
                #1 flush_i = 1'b1;
                @(posedge clk); #1 flush_i = 1'b0;
            end else if (sel == 1) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1 op_i = 2'($urandom_range(0, 3)); dividend_i = $urandom; divisor_i = $urandom;
                reg_waddr_i = 5'($urandom_range(0, 31)); start_i = 1'b1;
                @(posedge clk); #1 start_i = 1'b0;
            end
        end
        repeat (40) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
